// File: rtl/nes_timing_pkg.sv
// Shared NES timing definitions: PAL divider ratios and the clock/reset sequencer state type.
package nes_timing_pkg;

    localparam int PAL_CPU_DIV = 16;
    localparam int PAL_PPU_DIV = 5;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } clk_seq_state_t;

endpackage

// File: rtl/sync_bit.sv
// Multi-stage flip-flop synchroniser for a single asynchronous bit entering the clk domain.
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/master_clock_enables.sv
// Master-clock sequencer: qualifies PLL lock, releases the system reset and produces the
// CPU / PPU / alignment clock enables that every downstream block advances on.
module master_clock_enables
    import nes_timing_pkg::*;
#(
    parameter int CPU_DIV       = PAL_CPU_DIV,
    parameter int PPU_DIV       = PAL_PPU_DIV,
    parameter int SETTLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       pause,
    output logic       sys_rst_n,
    output logic       cpu_ce,
    output logic       ppu_ce,
    output logic       align_ce,
    output logic [7:0] lock_loss_cnt
);

    localparam int CPU_W    = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int PPU_W    = (PPU_DIV > 1) ? $clog2(PPU_DIV) : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CPU_W-1:0]    CPU_LAST    = CPU_W'(CPU_DIV - 1);
    localparam logic [PPU_W-1:0]    PPU_LAST    = PPU_W'(PPU_DIV - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    clk_seq_state_t      state;
    clk_seq_state_t      state_next;
    logic                lock_s;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [CPU_W-1:0]    cpu_cnt;
    logic [CPU_W-1:0]    cpu_cnt_next;
    logic [PPU_W-1:0]    ppu_cnt;
    logic [PPU_W-1:0]    ppu_cnt_next;
    logic                run_hold;
    logic                advance;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_comb begin
        state_next = state;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) state_next = SETTLE;
            end
            SETTLE: begin
                if (!lock_s)                        state_next = WAIT_LOCK;
                else if (settle_cnt == SETTLE_LAST) state_next = RUN;
            end
            RUN: begin
                if (!lock_s) state_next = WAIT_LOCK;
            end
            default: state_next = WAIT_LOCK;
        endcase
    end

    // Counters only move while RUN continues; entering or leaving RUN restarts the phase at 0,
    // and a lock loss overrides pause because run_hold is already false.
    always_comb begin
        run_hold     = (state == RUN) && (state_next == RUN);
        advance      = run_hold && !pause;
        cpu_cnt_next = '0;
        ppu_cnt_next = '0;
        if (advance) begin
            cpu_cnt_next = (cpu_cnt == CPU_LAST) ? '0 : cpu_cnt + 1'b1;
            ppu_cnt_next = (ppu_cnt == PPU_LAST) ? '0 : ppu_cnt + 1'b1;
        end else if (run_hold) begin
            cpu_cnt_next = cpu_cnt;
            ppu_cnt_next = ppu_cnt;
        end
    end

    // Enables are registered from the next counter value so the pulse sits on the last
    // phase of each period, i.e. in RUN cycle n with n a multiple of the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_LOCK;
            settle_cnt    <= '0;
            cpu_cnt       <= '0;
            ppu_cnt       <= '0;
            sys_rst_n     <= 1'b0;
            cpu_ce        <= 1'b0;
            ppu_ce        <= 1'b0;
            align_ce      <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else begin
            state      <= state_next;
            settle_cnt <= ((state == SETTLE) && (state_next == SETTLE)) ? settle_cnt + 1'b1 : '0;
            cpu_cnt    <= cpu_cnt_next;
            ppu_cnt    <= ppu_cnt_next;
            sys_rst_n  <= (state_next == RUN);
            cpu_ce     <= advance && (cpu_cnt_next == CPU_LAST);
            ppu_ce     <= advance && (ppu_cnt_next == PPU_LAST);
            align_ce   <= advance && (cpu_cnt_next == CPU_LAST) && (ppu_cnt_next == PPU_LAST);
            if ((state == RUN) && !lock_s && (lock_loss_cnt != 8'hFF)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_master_clock_enables.sv
// Self-checking bench for master_clock_enables: lock sequencing, enable cadence, pause,
// lock loss, saturation of the loss counter and asynchronous reset.
module tb_master_clock_enables;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_locked_f;
    logic       pause;

    logic       sys_rst_n, cpu_ce, ppu_ce, align_ce;
    logic [7:0] lock_loss_cnt;
    logic       f_sys_rst_n, f_cpu_ce, f_ppu_ce, f_align_ce;
    logic [7:0] f_lock_loss_cnt;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];
    logic [7:0] cnt_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    master_clock_enables u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .pause         (pause),
        .sys_rst_n     (sys_rst_n),
        .cpu_ce        (cpu_ce),
        .ppu_ce        (ppu_ce),
        .align_ce      (align_ce),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // Short settle time so hundreds of lock-loss events fit in a short run.
    master_clock_enables #(
        .SETTLE_CYCLES(4)
    ) u_fast (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked_f),
        .pause         (pause),
        .sys_rst_n     (f_sys_rst_n),
        .cpu_ce        (f_cpu_ce),
        .ppu_ce        (f_ppu_ce),
        .align_ce      (f_align_ce),
        .lock_loss_cnt (f_lock_loss_cnt)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- driver tasks / model ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] obs();
        return {sys_rst_n, cpu_ce, ppu_ce, align_ce};
    endfunction

    // Expected {sys_rst_n, cpu_ce, ppu_ce, align_ce} in unpaused RUN cycle n.
    function automatic logic [3:0] model_out(input int n);
        logic c, p;
        c = ((n % 16) == 0);
        p = ((n % 5) == 0);
        return {1'b1, c, p, c & p};
    endfunction

    task automatic wait_sys_rise(output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while ((sys_rst_n !== 1'b1) && (edges < 1200));
    endtask

    task automatic wait_sys_fall(output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while ((sys_rst_n !== 1'b0) && (edges < 50));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n        = 1'b0;
        pll_locked   = 1'b1;
        pll_locked_f = 1'b0;
        pause        = 1'b0;
        repeat (3) step();
        total++;
        if (obs() !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b", obs(), 4'b0000);
        end
        total++;
        if (lock_loss_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_loss_cnt got=%0d exp=0", lock_loss_cnt);
        end
        total++;
        if ({f_sys_rst_n, f_cpu_ce, f_ppu_ce, f_align_ce, f_lock_loss_cnt} !== 12'd0) begin
            bad++;
            $display("FAIL reset_fast_outputs got=%b exp=0",
                     {f_sys_rst_n, f_cpu_ce, f_ppu_ce, f_align_ce, f_lock_loss_cnt});
        end
    endtask

    task automatic test_reset_release();
        int e;
        #3 rst_n = 1'b1;
        wait_sys_rise(e);
        total++;
        if (e != 1027) begin
            bad++;
            $display("FAIL release_latency got=%0d exp=1027", e);
        end
        total++;
        if (obs() !== 4'b1000) begin
            bad++;
            $display("FAIL release_cycle1 got=%b exp=%b", obs(), 4'b1000);
        end
    endtask

    task automatic test_lock_loss();
        int e;
        logic [3:0] got, exp;
        for (int n = 2; n <= 62; n++) begin
            if (n == 41) pll_locked = 1'b0;
            exp_q.push_back((n <= 42) ? model_out(n) : 4'b0000);
            step();
            got = obs();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL lock_loss_cycle n=%0d got=%b exp=%b", n, got, exp);
            end
            if (n == 42 || n == 43) begin
                total++;
                if (lock_loss_cnt !== ((n == 43) ? 8'd1 : 8'd0)) begin
                    bad++;
                    $display("FAIL lock_loss_cnt n=%0d got=%0d exp=%0d", n, lock_loss_cnt,
                             (n == 43) ? 1 : 0);
                end
            end
        end
        pll_locked = 1'b1;
        wait_sys_rise(e);
        total++;
        if (e != 1027) begin
            bad++;
            $display("FAIL relock_latency got=%0d exp=1027", e);
        end
    endtask

    task automatic test_enables();
        int cpu_n = 0, ppu_n = 0, al_n = 0;
        logic [3:0] got, exp;
        for (int n = 2; n <= 160; n++) begin
            exp_q.push_back(model_out(n));
            step();
            got = obs();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL enables n=%0d got=%b exp=%b", n, got, exp);
            end
            if (n <= 80) begin
                cpu_n += int'(cpu_ce);
                ppu_n += int'(ppu_ce);
                al_n  += int'(align_ce);
            end
        end
        total++;
        if (cpu_n != 5 || ppu_n != 16 || al_n != 1) begin
            bad++;
            $display("FAIL enable_counts_80 got=%0d/%0d/%0d exp=5/16/1", cpu_n, ppu_n, al_n);
        end
    endtask

    task automatic test_lock_glitch();
        int e;
        pll_locked = 1'b0;
        wait_sys_fall(e);
        total++;
        if (e != 3) begin
            bad++;
            $display("FAIL fall_latency got=%0d exp=3", e);
        end
        total++;
        if (lock_loss_cnt !== 8'd2) begin
            bad++;
            $display("FAIL glitch_loss_cnt got=%0d exp=2", lock_loss_cnt);
        end
        repeat (5) step();
        pll_locked = 1'b1;
        repeat (503) step();
        total++;
        if (sys_rst_n !== 1'b0) begin
            bad++;
            $display("FAIL settle_sys_rst got=%b exp=0", sys_rst_n);
        end
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        wait_sys_rise(e);
        total++;
        if (e != 1027) begin
            bad++;
            $display("FAIL glitch_relock_latency got=%0d exp=1027", e);
        end
    endtask

    task automatic test_pause();
        int n = 1;
        int first_cpu = 0;
        logic [3:0] got, exp;
        for (int w = 2; w <= 40; w++) begin
            pause = (w >= 10 && w <= 19);
            if (pause) begin
                exp_q.push_back(4'b1000);
            end else begin
                n++;
                exp_q.push_back(model_out(n));
            end
            step();
            got = obs();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL pause_cycle w=%0d got=%b exp=%b", w, got, exp);
            end
            if (cpu_ce === 1'b1 && first_cpu == 0) first_cpu = w;
        end
        pause = 1'b0;
        total++;
        if (first_cpu != 26) begin
            bad++;
            $display("FAIL pause_first_cpu got=%0d exp=26", first_cpu);
        end
    endtask

    task automatic test_saturate();
        int k;
        logic [7:0] exp;
        for (int i = 1; i <= 300; i++) begin
            pll_locked_f = 1'b1;
            k = 0;
            do begin step(); k++; end while (f_sys_rst_n !== 1'b1 && k < 40);
            pll_locked_f = 1'b0;
            cnt_q.push_back((i < 255) ? 8'(i) : 8'd255);
            k = 0;
            do begin step(); k++; end while (f_sys_rst_n !== 1'b0 && k < 20);
            exp = cnt_q.pop_front();
            total++;
            if (f_lock_loss_cnt !== exp) begin
                bad++;
                $display("FAIL saturate_cnt i=%0d got=%0d exp=%0d", i, f_lock_loss_cnt, exp);
            end
        end
        total++;
        if (lock_loss_cnt !== 8'd2) begin
            bad++;
            $display("FAIL main_loss_cnt got=%0d exp=2", lock_loss_cnt);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) step();
        total++;
        if (sys_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_running got=%b exp=1", sys_rst_n);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({obs(), lock_loss_cnt} !== 12'd0) begin
            bad++;
            $display("FAIL async_reset got=%b exp=0", {obs(), lock_loss_cnt});
        end
        total++;
        if (f_lock_loss_cnt !== 8'd0) begin
            bad++;
            $display("FAIL async_reset_fast got=%0d exp=0", f_lock_loss_cnt);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_reset_release();
        test_lock_loss();
        test_enables();
        test_lock_glitch();
        test_pause();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
